// File: rtl/code_patch_pkg.sv
// Shared types for the code-patch controller: patch table entry layout and
// the output source selector.
package code_patch_pkg;

  localparam int PKG_ADDR_W = 13;
  localparam int PKG_DATA_W = 22;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] data;
    logic                  en;
  } patch_entry_t;

  typedef enum logic [1:0] {
    SEL_ROM   = 2'd0,
    SEL_PATCH = 2'd1,
    SEL_PAT   = 2'd2
  } out_sel_e;

endpackage

// File: rtl/code_patch_match.sv
// Combinational lookup of a fetch address in the patch table; the lowest
// enabled matching index wins.
module code_patch_match
  import code_patch_pkg::*;
#(
  parameter int NUM_PATCH = 3,
  parameter int IDX_W     = 2
) (
  input  patch_entry_t            i_entries [NUM_PATCH],
  input  logic [PKG_ADDR_W-1:0]   i_addr,
  output logic                    o_hit,
  output logic [IDX_W-1:0]        o_idx
);

  // Scanning from the top down lets the lowest index overwrite higher ones.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--) begin
      if (i_entries[i].en && (i_entries[i].addr == i_addr)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/code_patch_ctrl.sv
// Code-patch controller: substitutes table data on an address hit or emits a
// test pattern, through one registered valid/ready output stage.
module code_patch_ctrl
  import code_patch_pkg::*;
#(
  parameter int  NUM_PATCH = 3,
  parameter int  ADDR_W    = PKG_ADDR_W,
  parameter int  DATA_W    = PKG_DATA_W,
  parameter int  CNT_W     = 16,
  localparam int IDX_W     = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_we_i,
  input  logic [IDX_W-1:0]     cfg_idx_i,
  input  logic [ADDR_W-1:0]    cfg_addr_i,
  input  logic [DATA_W-1:0]    cfg_data_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_pat_gen_i,
  input  logic                 si_read_i,
  input  logic [ADDR_W-1:0]    si_addr_i,
  input  logic [DATA_W-1:0]    si_rdata_i,
  output logic                 si_ready_o,
  output logic                 so_valid_o,
  output logic [DATA_W-1:0]    so_data_o,
  output logic                 so_patched_o,
  input  logic                 so_ready_i,
  output logic [NUM_PATCH-1:0] patch_enable_o,
  output logic                 nopg_o,
  output logic [CNT_W-1:0]     hit_cnt_o
);

  patch_entry_t         r_table [NUM_PATCH];
  logic                 r_valid;
  logic [DATA_W-1:0]    r_data;
  logic                 r_patched;
  logic [DATA_W-1:0]    r_pat_cnt;
  logic [CNT_W-1:0]     r_hit_cnt;

  logic                 w_accept;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_idx;
  out_sel_e             w_sel;
  logic [DATA_W-1:0]    w_data;
  logic [NUM_PATCH-1:0] w_en_vec;

  // Handshake: a request transfers when si_read_i and si_ready_o are both
  // high; the output slot may refill in the same cycle it is drained.
  assign si_ready_o = !r_valid || so_ready_i;
  assign w_accept   = si_read_i && si_ready_o;

  code_patch_match #(
    .NUM_PATCH (NUM_PATCH),
    .IDX_W     (IDX_W)
  ) u_match (
    .i_entries (r_table),
    .i_addr    (PKG_ADDR_W'(si_addr_i)),
    .o_hit     (w_hit),
    .o_idx     (w_idx)
  );

  always_comb begin
    w_sel  = SEL_ROM;
    w_data = si_rdata_i;
    if (cfg_pat_gen_i) begin
      w_sel  = SEL_PAT;
      w_data = r_pat_cnt;
    end else if (w_hit) begin
      w_sel  = SEL_PATCH;
      w_data = DATA_W'(r_table[w_idx].data);
    end
  end

  always_comb begin
    w_en_vec = '0;
    for (int i = 0; i < NUM_PATCH; i++) begin
      w_en_vec[i] = r_table[i].en;
    end
  end

  // Out-of-range indices match no entry, so such writes fall away.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_PATCH; i++) begin
        r_table[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PATCH; i++) begin
        if (cfg_we_i && (IDX_W'(i) == cfg_idx_i)) begin
          r_table[i] <= '{addr: PKG_ADDR_W'(cfg_addr_i),
                          data: PKG_DATA_W'(cfg_data_i),
                          en:   cfg_en_i};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_patched <= 1'b0;
      r_pat_cnt <= '0;
      r_hit_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_data    <= w_data;
        r_patched <= (w_sel == SEL_PATCH);
      end else if (so_ready_i) begin
        r_valid   <= 1'b0;
      end
      if (!cfg_pat_gen_i) begin
        r_pat_cnt <= '0;
      end else if (w_accept) begin
        r_pat_cnt <= r_pat_cnt + 1'b1;
      end
      if (w_accept && (w_sel == SEL_PATCH) && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
    end
  end

  assign so_valid_o     = r_valid;
  assign so_data_o      = r_data;
  assign so_patched_o   = r_patched;
  assign patch_enable_o = w_en_vec;
  assign nopg_o         = ~|w_en_vec;
  assign hit_cnt_o      = r_hit_cnt;

endmodule

// File: doc/code_patch_ctrl.md
Name: code_patch_ctrl

Overview:
Parametrised code-patch controller placed between the instruction fetch port (si_*) and the core fetch path. It holds NUM_PATCH programmable address/data patch entries. It substitutes patch data for ROM data on an address hit, and alternatively emits a generated test pattern when pattern-generation mode is on. The fetch output is a registered valid/ready stage with backpressure and a saturating patch-hit counter.

Parameters:
NUM_PATCH, 3, number of patch entries (>=1)
ADDR_W, 13, fetch/patch address width
DATA_W, 22, fetch/patch data width
CNT_W, 16, width of the hit counter
IDX_W, $clog2(NUM_PATCH) (min 1), entry index width (derived, localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
cfg_we_i  in  1  patch table write strobe
cfg_idx_i  in  IDX_W  entry being written
cfg_addr_i  in  ADDR_W  patch address written
cfg_data_i  in  DATA_W  patch data written
cfg_en_i  in  1  enable bit written into the entry
cfg_pat_gen_i  in  1  pattern-generation mode
si_read_i  in  1  fetch request valid
si_addr_i  in  ADDR_W  fetch address
si_rdata_i  in  DATA_W  ROM data for si_addr_i, same cycle
si_ready_o  out  1  fetch request accepted when high with si_read_i
so_valid_o  out  1  output data valid
so_data_o  out  DATA_W  output fetch data
so_patched_o  out  1  so_data_o came from a patch entry
so_ready_i  in  1  downstream ready
patch_enable_o  out  NUM_PATCH  per-entry enable bits
nopg_o  out  1  high when no entry is enabled
hit_cnt_o  out  CNT_W  saturating count of patched fetches

Behaviour:
- Reset: all entries addr=0, data=0, en=0. so_valid_o=0, so_data_o=0, so_patched_o=0, pat_cnt=0, hit_cnt_o=0, patch_enable_o=0, nopg_o=1. si_ready_o=1 in the cycle after reset.
- Table write: when cfg_we_i=1, entry[cfg_idx_i] takes {cfg_addr_i, cfg_data_i, cfg_en_i} on the clock edge. If cfg_idx_i >= NUM_PATCH, the write is ignored.
  - patch_enable_o and nopg_o are registered views of the table, updated in the same edge as the write.
- Handshake: si_ready_o = !so_valid_o | so_ready_i (combinational). A fetch is accepted on a cycle with si_read_i & si_ready_o.
  - so_valid_o is set on accept and cleared when so_ready_i=1 with no new accept.
  - so_data_o and so_patched_o hold stable while so_valid_o & !so_ready_i.
- Latency: exactly 1 cycle from accept to so_valid_o, and back-to-back accepts give full throughput.
- Lookup on accept, using table state before any same-cycle write:
  - hit = any entry with en=1 and addr == si_addr_i.
  - Lowest matching index wins.
- Output selection, in priority order:
  - cfg_pat_gen_i=1: so_data_o = pat_cnt zero-extended or truncated to DATA_W, so_patched_o=0, pat_cnt+1 (wraps modulo 2^DATA_W).
  - else hit: so_data_o = entry data, so_patched_o=1, hit_cnt_o+1 (saturates at all-ones).
  - else: so_data_o = si_rdata_i, so_patched_o=0.
- pat_cnt clears to 0 on any cycle where cfg_pat_gen_i=0.
- Reset mid-transaction drops any held output (so_valid_o=0) and clears the table.

Decomposition:
- Package code_patch_pkg holds:
  - typedef patch_entry_t {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; logic en;}, parametrised via package localparams or an interface-level struct.
  - Enum out_sel_e {SEL_ROM, SEL_PATCH, SEL_PAT}.
- Sub-module code_patch_match: combinational, takes the entry array and the address, returns hit and idx. It is a lowest-index priority encoder.

Test Plan:
- Reset, then fetch addr 0x010 with rdata 0x0ABCDE -> next cycle so_valid_o=1, so_data_o=0x0ABCDE, so_patched_o=0, nopg_o=1.
- Program entry1 {0x010, 0x3FFFFF, en=1}, then fetch 0x010 -> so_data_o=0x3FFFFF, so_patched_o=1, hit_cnt_o=1, patch_enable_o=3'b010, nopg_o=0.
- Program entry0 and entry2 both at 0x020 (data 0x111, 0x222), then fetch 0x020 -> 0x111 (lowest index wins).
- Hold so_ready_i=0 for 3 cycles with si_read_i=1 -> si_ready_o=0, so_data_o stable. Release -> the next request is accepted the same cycle.
- cfg_pat_gen_i=1 with 4 fetches to a patched address -> so_data_o = 0,1,2,3, so_patched_o=0, hit_cnt_o unchanged. Dropping the mode then re-raising it restarts at 0.
- Same-cycle write of entry0 to 0x030 and fetch of 0x030 -> ROM data (old table). Preload hit_cnt_o near max with CNT_W=4: 16 or more hits -> hit_cnt_o holds at 0xF.
